// File: rtl/tri_trace_pkg.sv
// Shared definitions for the trace capture block: FSM state encoding and
// timestamp width (used only when TRI_TRACE_TSTAMP_EN is defined).
package tri_trace_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE  = 2'b00,
        TRC_ARMED = 2'b01,
        TRC_POST  = 2'b10,
        TRC_DONE  = 2'b11
    } trc_state_t;

    localparam int TSTAMP_W = 16;

endpackage

// File: rtl/tri_trace_capture_if.sv
// Readout port of the trace capture buffer (valid/ready, oldest entry first).
// With TRI_TRACE_TSTAMP_EN defined, the port also carries rd_tstamp.
interface tri_trace_capture_if #(
    parameter int DBG_WIDTH = 32
);
`ifdef TRI_TRACE_TSTAMP_EN
    import tri_trace_pkg::*;
`endif

    logic                 rd_valid;
    logic                 rd_ready;
    logic [DBG_WIDTH-1:0] rd_data;
    logic                 rd_last;
`ifdef TRI_TRACE_TSTAMP_EN
    logic [0:TSTAMP_W-1]  rd_tstamp;
`endif

    // capture block drives data out
    modport master (
        output rd_valid,
        output rd_data,
        output rd_last,
`ifdef TRI_TRACE_TSTAMP_EN
        output rd_tstamp,
`endif
        input  rd_ready
    );

    // readout consumer
    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_last,
`ifdef TRI_TRACE_TSTAMP_EN
        input  rd_tstamp,
`endif
        output rd_ready
    );

endinterface

// File: rtl/tri_trace_ram.sv
// Flop-array capture buffer: one synchronous write port, one asynchronous
// read port. Data is not reset; entries are only read after being written.
module tri_trace_ram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              nclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    // write one entry per enabled cycle
    always_ff @(posedge nclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tri_trace_capture.sv
// Trace capture: samples the debug trace bus into a circular buffer while
// armed, stops a programmable number of valid samples after a masked pattern
// trigger, then drains the frozen buffer oldest-first over a valid/ready port.
// Optional feature macro: TRI_TRACE_TSTAMP_EN (16-bit timestamp per entry).
module tri_trace_capture import tri_trace_pkg::*; #(
    parameter int DBG_WIDTH  = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int POST_W     = 8
) (
    input  logic                  nclk,
    input  logic                  rst_n,
    input  logic [DBG_WIDTH-1:0]  trace_data_in,
    input  logic [3:0]            coretrace_ctrls_in,
    input  logic                  cfg_arm,
    input  logic                  cfg_clear,
    input  logic [DBG_WIDTH-1:0]  cfg_trig_mask,
    input  logic [DBG_WIDTH-1:0]  cfg_trig_pattern,
    input  logic [POST_W-1:0]     cfg_post_count,
    tri_trace_capture_if.master   rd,
    output logic [1:0]            sts_state,
    output logic                  sts_trig_fired,
    output logic [DEPTH_LOG2:0]   sts_entries
);

`ifdef TRI_TRACE_TSTAMP_EN
    localparam int ENT_W = DBG_WIDTH + TSTAMP_W;
`else
    localparam int ENT_W = DBG_WIDTH;
`endif

    // entry count of a completely filled buffer
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    trc_state_t              state;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    wrapped;
    logic [DEPTH_LOG2:0]     rd_remaining;
    logic [DEPTH_LOG2:0]     done_entries;
    logic [POST_W-1:0]       post_cnt;
    logic                    trig_fired;

    logic                    sample;
    logic                    match;
    logic                    wr_en;
    logic                    enter_done;
    logic                    rd_valid_i;
    logic                    pop;
    logic [DEPTH_LOG2-1:0]   wr_ptr_nxt;
    logic                    wrapped_nxt;
    logic [ENT_W-1:0]        ram_wdata;
    logic [ENT_W-1:0]        ram_rdata;

    // control bits 3:1 carry nothing this block needs
    logic unused_ctrls;
    assign unused_ctrls = ^coretrace_ctrls_in[3:1];

    // trigger match, write enable and DONE-entry detection
    always_comb begin
        sample      = coretrace_ctrls_in[0];
        match       = sample &&
                      (((trace_data_in ^ cfg_trig_pattern) & cfg_trig_mask) == '0);
        wr_en       = sample && !cfg_clear &&
                      ((state == TRC_ARMED) || (state == TRC_POST));
        wr_ptr_nxt  = wr_ptr + DEPTH_LOG2'(1);
        wrapped_nxt = wrapped || (wr_ptr == '1);
        enter_done  = wr_en &&
                      (((state == TRC_ARMED) && match && (cfg_post_count == '0)) ||
                       ((state == TRC_POST) && (post_cnt == POST_W'(1))));
        rd_valid_i  = (state == TRC_DONE) && (rd_remaining != '0);
        pop         = rd_valid_i && rd.rd_ready;
    end

    // capture FSM, pointers and readout bookkeeping
    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= TRC_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wrapped      <= 1'b0;
            rd_remaining <= '0;
            done_entries <= '0;
            post_cnt     <= '0;
            trig_fired   <= 1'b0;
        end else if (cfg_clear) begin
            // clear wins over everything, including a same-cycle arm
            state        <= TRC_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wrapped      <= 1'b0;
            rd_remaining <= '0;
            done_entries <= '0;
            post_cnt     <= '0;
            trig_fired   <= 1'b0;
        end else begin
            case (state)
                TRC_IDLE, TRC_DONE: begin
                    if (cfg_arm) begin
                        // re-arm drops any unfinished readout
                        state        <= TRC_ARMED;
                        wr_ptr       <= '0;
                        wrapped      <= 1'b0;
                        trig_fired   <= 1'b0;
                        rd_ptr       <= '0;
                        rd_remaining <= '0;
                        done_entries <= '0;
                    end else if (pop) begin
                        rd_ptr       <= rd_ptr + DEPTH_LOG2'(1);
                        rd_remaining <= rd_remaining - 1'b1;
                    end
                end
                default: begin
                    // ARMED / POST: capture only on valid sample cycles
                    if (wr_en) begin
                        wr_ptr  <= wr_ptr_nxt;
                        wrapped <= wrapped_nxt;
                        if (state == TRC_ARMED) begin
                            if (match) begin
                                trig_fired <= 1'b1;
                                post_cnt   <= cfg_post_count;
                                state      <= (cfg_post_count == '0) ? TRC_DONE : TRC_POST;
                            end
                        end else begin
                            post_cnt <= post_cnt - 1'b1;
                            if (post_cnt == POST_W'(1)) state <= TRC_DONE;
                        end
                        if (enter_done) begin
                            // freeze the buffer: oldest entry sits at wr_ptr once wrapped
                            rd_ptr       <= wrapped_nxt ? wr_ptr_nxt : '0;
                            rd_remaining <= wrapped_nxt ? FULL_CNT : {1'b0, wr_ptr_nxt};
                            done_entries <= wrapped_nxt ? FULL_CNT : {1'b0, wr_ptr_nxt};
                        end
                    end
                end
            endcase
        end
    end

`ifdef TRI_TRACE_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;

    // free-running timestamp, restarted at each arm
    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n)       tstamp <= '0;
        else if (cfg_arm) tstamp <= '0;
        else              tstamp <= tstamp + 1'b1;
    end

    assign ram_wdata    = {tstamp, trace_data_in};
    assign rd.rd_tstamp = rd_valid_i ? ram_rdata[ENT_W-1:DBG_WIDTH] : '0;
`else
    assign ram_wdata    = trace_data_in;
`endif

    tri_trace_ram #(
        .WIDTH  (ENT_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .nclk   (nclk),
        .we     (wr_en),
        .waddr  (wr_ptr),
        .wdata  (ram_wdata),
        .raddr  (rd_ptr),
        .rdata  (ram_rdata)
    );

    // data is gated so outputs read as zero whenever nothing is offered
    assign rd.rd_valid  = rd_valid_i;
    assign rd.rd_data   = rd_valid_i ? ram_rdata[DBG_WIDTH-1:0] : '0;
    assign rd.rd_last   = rd_valid_i && (rd_remaining == (DEPTH_LOG2+1)'(1));

    assign sts_state      = state;
    assign sts_trig_fired = trig_fired;
    assign sts_entries    = (state == TRC_DONE) ? done_entries
                          : (wrapped ? FULL_CNT : {1'b0, wr_ptr});

endmodule

// File: tb/tb_tri_trace_capture.sv
// Directed bench for tri_trace_capture: linear stimulus, hand-computed
// expectations, immediate assertions at each check point.
module tb_tri_trace_capture;

    logic        nclk;
    logic        rst_n;
    logic [31:0] trace_data_in;
    logic [3:0]  coretrace_ctrls_in;
    logic        cfg_arm;
    logic        cfg_clear;
    logic [31:0] cfg_trig_mask;
    logic [31:0] cfg_trig_pattern;
    logic [7:0]  cfg_post_count;
    logic [1:0]  sts_state;
    logic        sts_trig_fired;
    logic [5:0]  sts_entries;

    int tests = 0;
    int fails = 0;

    tri_trace_capture_if #(.DBG_WIDTH(32)) rd_if ();

    tri_trace_capture #(
        .DBG_WIDTH  (32),
        .DEPTH_LOG2 (5),
        .POST_W     (8)
    ) dut (
        .nclk               (nclk),
        .rst_n              (rst_n),
        .trace_data_in      (trace_data_in),
        .coretrace_ctrls_in (coretrace_ctrls_in),
        .cfg_arm            (cfg_arm),
        .cfg_clear          (cfg_clear),
        .cfg_trig_mask      (cfg_trig_mask),
        .cfg_trig_pattern   (cfg_trig_pattern),
        .cfg_post_count     (cfg_post_count),
        .rd                 (rd_if.master),
        .sts_state          (sts_state),
        .sts_trig_fired     (sts_trig_fired),
        .sts_entries        (sts_entries)
    );

    initial nclk = 1'b0;
    always #5 nclk = ~nclk;

    task automatic tick;
        @(posedge nclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] d);
        coretrace_ctrls_in = {3'b000, s};
        trace_data_in      = d;
        tick();
    endtask

    task automatic arm_pulse;
        cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        trace_data_in      = '0;
        coretrace_ctrls_in = '0;
        cfg_arm            = 1'b0;
        cfg_clear          = 1'b0;
        cfg_trig_mask      = '0;
        cfg_trig_pattern   = '0;
        cfg_post_count     = '0;
        rd_if.rd_ready     = 1'b0;

        // reset state
        #1;
        chk("rst_state",   64'(sts_state), 64'd0);
        chk("rst_trig",    64'(sts_trig_fired), 64'd0);
        chk("rst_entries", 64'(sts_entries), 64'd0);
        chk("rst_valid",   64'(rd_if.rd_valid), 64'd0);
        chk("rst_data",    64'(rd_if.rd_data), 64'd0);
        chk("rst_last",    64'(rd_if.rd_last), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // mask=0, post=3: first sample triggers, four entries total
        cfg_trig_mask  = 32'h0;
        cfg_post_count = 8'd3;
        arm_pulse();
        chk("t1_armed", 64'(sts_state), 64'd1);
        chk("t1_trig0", 64'(sts_trig_fired), 64'd0);
        drive(1'b1, 32'd1);
        chk("t1_post",  64'(sts_state), 64'd2);
        chk("t1_trig1", 64'(sts_trig_fired), 64'd1);
        chk("t1_live",  64'(sts_entries), 64'd1);
        drive(1'b1, 32'd2);
        drive(1'b1, 32'd3);
        drive(1'b1, 32'd4);
        coretrace_ctrls_in = '0;
        chk("t1_done",    64'(sts_state), 64'd3);
        chk("t1_entries", 64'(sts_entries), 64'd4);
        chk("t1_valid",   64'(rd_if.rd_valid), 64'd1);
        rd_if.rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t1_rd_data", 64'(rd_if.rd_data), 64'(i));
            chk("t1_rd_last", 64'(rd_if.rd_last), 64'(i == 4));
            tick();
        end
        rd_if.rd_ready = 1'b0;
        chk("t1_empty",      64'(rd_if.rd_valid), 64'd0);
        chk("t1_stay_done",  64'(sts_state), 64'd3);
        chk("t1_entries_hd", 64'(sts_entries), 64'd4);

        // wrap: trigger at sample 40 (0xAA), post=10, keep samples 19..50
        cfg_trig_mask    = 32'hFFFF_FFFF;
        cfg_trig_pattern = 32'h0000_00AA;
        cfg_post_count   = 8'd10;
        arm_pulse();
        for (int i = 1; i <= 55; i++) begin
            drive(1'b1, (i == 40) ? 32'hAA : 32'(i));
            if (i == 39) begin
                chk("t2_no_trig", 64'(sts_trig_fired), 64'd0);
                chk("t2_armed",   64'(sts_state), 64'd1);
            end
            if (i == 40) begin
                chk("t2_trig",    64'(sts_trig_fired), 64'd1);
                chk("t2_post",    64'(sts_state), 64'd2);
                chk("t2_live32",  64'(sts_entries), 64'd32);
            end
        end
        coretrace_ctrls_in = '0;
        chk("t2_done",    64'(sts_state), 64'd3);
        chk("t2_entries", 64'(sts_entries), 64'd32);
        chk("t2_first",   64'(rd_if.rd_data), 64'd19);
        rd_if.rd_ready = 1'b1;
        for (int k = 19; k <= 50; k++) begin
            chk("t2_rd_data", 64'(rd_if.rd_data), (k == 40) ? 64'hAA : 64'(k));
            chk("t2_rd_last", 64'(rd_if.rd_last), 64'(k == 50));
            tick();
        end
        rd_if.rd_ready = 1'b0;
        chk("t2_empty", 64'(rd_if.rd_valid), 64'd0);

        // sample gating during POST (post=5), then backpressure on readout
        cfg_trig_mask  = 32'h0;
        cfg_post_count = 8'd5;
        arm_pulse();
        drive(1'b1, 32'h100);
        chk("t3_post", 64'(sts_state), 64'd2);
        for (int j = 1; j <= 4; j++) begin
            drive(1'b1, 32'h100 + 32'(j));
            drive(1'b0, 32'hBAD0 + 32'(j));
        end
        chk("t3_still_post", 64'(sts_state), 64'd2);
        chk("t3_live5",      64'(sts_entries), 64'd5);
        drive(1'b1, 32'h105);
        coretrace_ctrls_in = '0;
        chk("t3_done",    64'(sts_state), 64'd3);
        chk("t3_entries", 64'(sts_entries), 64'd6);
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("t3_rd_data", 64'(rd_if.rd_data), 64'h100 + 64'(i));
            tick();
        end
        rd_if.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_data",  64'(rd_if.rd_data), 64'h102);
            chk("t4_hold_valid", 64'(rd_if.rd_valid), 64'd1);
            chk("t4_hold_last",  64'(rd_if.rd_last), 64'd0);
            tick();
        end
        rd_if.rd_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("t4_rd_data", 64'(rd_if.rd_data), 64'h100 + 64'(i));
            chk("t4_rd_last", 64'(rd_if.rd_last), 64'(i == 5));
            tick();
        end
        rd_if.rd_ready = 1'b0;
        chk("t4_empty", 64'(rd_if.rd_valid), 64'd0);

        // arm and clear together in DONE: clear wins
        cfg_arm   = 1'b1;
        cfg_clear = 1'b1;
        tick();
        cfg_arm   = 1'b0;
        cfg_clear = 1'b0;
        chk("t5_idle",    64'(sts_state), 64'd0);
        chk("t5_entries", 64'(sts_entries), 64'd0);
        chk("t5_valid",   64'(rd_if.rd_valid), 64'd0);
        chk("t5_trig",    64'(sts_trig_fired), 64'd0);

        // asynchronous reset mid-POST, then a normal capture with post=0
        cfg_post_count = 8'd10;
        arm_pulse();
        drive(1'b1, 32'h200);
        drive(1'b1, 32'h201);
        drive(1'b1, 32'h202);
        chk("t6_post",    64'(sts_state), 64'd2);
        chk("t6_live3",   64'(sts_entries), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state",   64'(sts_state), 64'd0);
        chk("t6_rst_trig",    64'(sts_trig_fired), 64'd0);
        chk("t6_rst_entries", 64'(sts_entries), 64'd0);
        chk("t6_rst_valid",   64'(rd_if.rd_valid), 64'd0);
        chk("t6_rst_data",    64'(rd_if.rd_data), 64'd0);
        #1;
        rst_n = 1'b1;
        coretrace_ctrls_in = '0;
        tick();
        cfg_post_count = 8'd0;
        arm_pulse();
        chk("t6_armed", 64'(sts_state), 64'd1);
        drive(1'b1, 32'h55);
        coretrace_ctrls_in = '0;
        chk("t6_done",    64'(sts_state), 64'd3);
        chk("t6_trig",    64'(sts_trig_fired), 64'd1);
        chk("t6_entries", 64'(sts_entries), 64'd1);
        chk("t6_valid",   64'(rd_if.rd_valid), 64'd1);
        chk("t6_data",    64'(rd_if.rd_data), 64'h55);
        chk("t6_last",    64'(rd_if.rd_last), 64'd1);
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
        chk("t6_empty",   64'(rd_if.rd_valid), 64'd0);
        chk("t6_stay",    64'(sts_state), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
